// File: rtl/act_pkg.sv
// act_pkg: shared constants for the PWL sigmoid/tanh activation pipeline.
// Fixed-point helpers return values with frac+GUARD_BITS fraction bits.
package act_pkg;

  localparam logic ACT_SIGMOID = 1'b0;
  localparam logic ACT_TANH    = 1'b1;

  localparam int GUARD_BITS = 5;

  // num / 2^shr, scaled to frac+GUARD_BITS fraction bits
  function automatic logic [31:0] act_q(
    input int num,
    input int shr,
    input int frac
  );
    return 32'(num) << (frac + GUARD_BITS - shr);
  endfunction

  function automatic logic [31:0] act_bp_1p0(input int frac);
    return act_q(1, 0, frac);
  endfunction

  function automatic logic [31:0] act_bp_2p375(input int frac);
    return act_q(19, 3, frac);
  endfunction

  function automatic logic [31:0] act_bp_5p0(input int frac);
    return act_q(5, 0, frac);
  endfunction

  function automatic logic [31:0] act_off_0p5(input int frac);
    return act_q(1, 1, frac);
  endfunction

  function automatic logic [31:0] act_off_0p625(input int frac);
    return act_q(5, 3, frac);
  endfunction

  function automatic logic [31:0] act_off_0p84375(input int frac);
    return act_q(27, 5, frac);
  endfunction

  function automatic logic [31:0] act_off_1p0(input int frac);
    return act_q(1, 0, frac);
  endfunction

endpackage

// File: rtl/plan_segment.sv
// plan_segment: four-segment PLAN sigmoid on a non-negative magnitude a.
// a has FRAC_BITS fraction bits; p has FRAC_BITS+GUARD_BITS and lies in [0.5,1.0].
module plan_segment
  import act_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FRAC_BITS  = 4
) (
  input  logic [DATA_WIDTH+1:0]           a,
  output logic [FRAC_BITS+GUARD_BITS+1:0] p
);

  localparam int CW = DATA_WIDTH + GUARD_BITS + 3;
  localparam int PW = FRAC_BITS + GUARD_BITS + 2;

  localparam logic [CW-1:0] BP_1P0   = CW'(act_bp_1p0(FRAC_BITS));
  localparam logic [CW-1:0] BP_2P375 = CW'(act_bp_2p375(FRAC_BITS));
  localparam logic [CW-1:0] BP_5P0   = CW'(act_bp_5p0(FRAC_BITS));
  localparam logic [CW-1:0] OFF_0P5  = CW'(act_off_0p5(FRAC_BITS));
  localparam logic [CW-1:0] OFF_0P625 = CW'(act_off_0p625(FRAC_BITS));
  localparam logic [CW-1:0] OFF_0P84 = CW'(act_off_0p84375(FRAC_BITS));
  localparam logic [CW-1:0] OFF_1P0  = CW'(act_off_1p0(FRAC_BITS));

  logic [CW-1:0] ai;
  logic [CW-1:0] pc;
  logic          seg_sat;
  logic          seg_hi;
  logic          seg_mid;
  logic          seg_lo;

  // Select the segment and evaluate slope/offset at guard precision
  always_comb begin
    ai      = CW'(a) << GUARD_BITS;
    seg_sat = (ai >= BP_5P0);
    seg_hi  = !seg_sat && (ai >= BP_2P375);
    seg_mid = (ai < BP_2P375) && (ai >= BP_1P0);
    seg_lo  = (ai < BP_1P0);
    pc      = OFF_1P0;
    unique case (1'b1)
      seg_sat: pc = OFF_1P0;
      seg_hi:  pc = (ai >> 5) + OFF_0P84;
      seg_mid: pc = (ai >> 3) + OFF_0P625;
      seg_lo:  pc = (ai >> 2) + OFF_0P5;
      default: pc = OFF_1P0;
    endcase
    p = PW'(pc);
  end

endmodule

// File: rtl/pwl_activation_pipe.sv
// pwl_activation_pipe: 3-stage PLAN sigmoid / tanh with valid-ready and tag.
// Define PWL_ACT_TANH_EN to include tanh (2*sigma(2x)-1); else sigmoid-only.
module pwl_activation_pipe
  import act_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FRAC_BITS  = 4,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_mode,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [TAG_WIDTH-1:0]  out_tag
);

  localparam int XW = DATA_WIDTH + 2;
  localparam int PW = FRAC_BITS + GUARD_BITS + 2;
  localparam int VW = PW + 2;
  localparam int SW = ((VW > DATA_WIDTH) ? VW : DATA_WIDTH) + 1;

  localparam logic [PW-1:0] ONE = PW'(act_off_1p0(FRAC_BITS));
  localparam logic signed [SW-1:0] HALF = SW'(1 << (GUARD_BITS - 1));
  localparam logic signed [SW-1:0] SAT_MAX =
    SW'({1'b0, {(DATA_WIDTH-1){1'b1}}});
  localparam logic signed [SW-1:0] SAT_MIN = -SAT_MAX - SW'(1);

  logic advance;

  logic                  s1_vld_q, s1_vld_d;
  logic [XW-1:0]         s1_a_q, s1_a_d;
  logic                  s1_neg_q, s1_neg_d;
  logic [TAG_WIDTH-1:0]  s1_tag_q, s1_tag_d;

  logic                  s2_vld_q, s2_vld_d;
  logic [PW-1:0]         s2_p_q, s2_p_d;
  logic                  s2_neg_q, s2_neg_d;
  logic [TAG_WIDTH-1:0]  s2_tag_q, s2_tag_d;

  logic                  out_vld_q, out_vld_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [TAG_WIDTH-1:0]  out_tag_q, out_tag_d;

`ifdef PWL_ACT_TANH_EN
  logic                  s1_tanh_q, s1_tanh_d;
  logic                  s2_tanh_q, s2_tanh_d;
`else
  logic                  unused_mode;
  assign unused_mode = in_mode;
`endif

  logic signed [XW-1:0]  x2;
  logic [PW-1:0]         p;
  logic [PW-1:0]         y;
  logic signed [VW-1:0]  v;
  logic signed [SW-1:0]  r;
  logic signed [SW-1:0]  r_sat;

  assign advance   = !out_vld_q || out_ready;
  assign in_ready  = advance;
  assign out_valid = out_vld_q;
  assign out_data  = out_data_q;
  assign out_tag   = out_tag_q;

  plan_segment #(
    .DATA_WIDTH (DATA_WIDTH),
    .FRAC_BITS  (FRAC_BITS)
  ) u_plan (
    .a (s1_a_q),
    .p (p)
  );

  // Input conditioning: optional doubling for tanh, sign-extended otherwise
  always_comb begin
    x2 = {{2{in_data[DATA_WIDTH-1]}}, in_data};
`ifdef PWL_ACT_TANH_EN
    if (in_mode == ACT_TANH) begin
      x2 = {in_data[DATA_WIDTH-1], in_data, 1'b0};
    end
`endif
  end

  // Output stage math: symmetry, optional 2y-1, round half up, saturate
  always_comb begin
    y = s2_neg_q ? (ONE - s2_p_q) : s2_p_q;
    v = VW'(y);
`ifdef PWL_ACT_TANH_EN
    if (s2_tanh_q) begin
      v = VW'({y, 1'b0}) - VW'(ONE);
    end
`endif
    r = (SW'(v) + HALF) >>> GUARD_BITS;
    r_sat = r;
    if (r > SAT_MAX) begin
      r_sat = SAT_MAX;
    end else if (r < SAT_MIN) begin
      r_sat = SAT_MIN;
    end
  end

  // Next state: every stage moves together on advance, else holds
  always_comb begin
    s1_vld_d   = s1_vld_q;
    s1_a_d     = s1_a_q;
    s1_neg_d   = s1_neg_q;
    s1_tag_d   = s1_tag_q;
    s2_vld_d   = s2_vld_q;
    s2_p_d     = s2_p_q;
    s2_neg_d   = s2_neg_q;
    s2_tag_d   = s2_tag_q;
    out_vld_d  = out_vld_q;
    out_data_d = out_data_q;
    out_tag_d  = out_tag_q;
`ifdef PWL_ACT_TANH_EN
    s1_tanh_d  = s1_tanh_q;
    s2_tanh_d  = s2_tanh_q;
`endif
    if (advance) begin
      s1_vld_d  = in_valid;
      s1_a_d    = x2[XW-1] ? $unsigned(-x2) : $unsigned(x2);
      s1_neg_d  = x2[XW-1];
      s1_tag_d  = in_tag;
      s2_vld_d  = s1_vld_q;
      s2_p_d    = p;
      s2_neg_d  = s1_neg_q;
      s2_tag_d  = s1_tag_q;
      out_vld_d = s2_vld_q;
`ifdef PWL_ACT_TANH_EN
      s1_tanh_d = (in_mode == ACT_TANH);
      s2_tanh_d = s1_tanh_q;
`endif
      if (s2_vld_q) begin
        out_data_d = DATA_WIDTH'(r_sat);
        out_tag_d  = s2_tag_q;
      end
    end
  end

  // Pipeline registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q   <= 1'b0;
      s1_a_q     <= '0;
      s1_neg_q   <= 1'b0;
      s1_tag_q   <= '0;
      s2_vld_q   <= 1'b0;
      s2_p_q     <= '0;
      s2_neg_q   <= 1'b0;
      s2_tag_q   <= '0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_tag_q  <= '0;
`ifdef PWL_ACT_TANH_EN
      s1_tanh_q  <= 1'b0;
      s2_tanh_q  <= 1'b0;
`endif
    end else begin
      s1_vld_q   <= s1_vld_d;
      s1_a_q     <= s1_a_d;
      s1_neg_q   <= s1_neg_d;
      s1_tag_q   <= s1_tag_d;
      s2_vld_q   <= s2_vld_d;
      s2_p_q     <= s2_p_d;
      s2_neg_q   <= s2_neg_d;
      s2_tag_q   <= s2_tag_d;
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
      out_tag_q  <= out_tag_d;
`ifdef PWL_ACT_TANH_EN
      s1_tanh_q  <= s1_tanh_d;
      s2_tanh_q  <= s2_tanh_d;
`endif
    end
  end

endmodule

// File: tb/tb_pwl_activation_pipe.sv
// tb_pwl_activation_pipe: scoreboard bench for the PWL activation pipeline.
// Expected results come from an integer model in units of 1/512.
module tb_pwl_activation_pipe;

`ifdef PWL_ACT_TANH_EN
  localparam bit TANH_ON = 1'b1;
`else
  localparam bit TANH_ON = 1'b0;
`endif

  typedef struct {
    logic [7:0] data;
    logic [3:0] tag;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       in_mode = 1'b0;
  logic [3:0] in_tag = 4'h0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic [3:0] out_tag;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  exp_t sb[$];

  pwl_activation_pipe #(
    .DATA_WIDTH (8),
    .FRAC_BITS  (4),
    .TAG_WIDTH  (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [7:0] model(input logic [7:0] x, input logic m);
    int xi, x2, neg, a512, p, y, v, r;
    xi = int'($signed(x));
    x2 = (m && TANH_ON) ? 2 * xi : xi;
    neg = (x2 < 0) ? 1 : 0;
    a512 = (neg != 0 ? -x2 : x2) * 32;
    if (a512 >= 2560) p = 512;
    else if (a512 >= 1216) p = a512 / 32 + 432;
    else if (a512 >= 512) p = a512 / 8 + 320;
    else p = a512 / 4 + 256;
    y = (neg != 0) ? 512 - p : p;
    v = (m && TANH_ON) ? 2 * y - 512 : y;
    r = (v + 16) >>> 5;
    if (r > 127) r = 127;
    if (r < -128) r = -128;
    return r[7:0];
  endfunction

  task automatic step(
    input  logic       v,
    input  logic [7:0] xd,
    input  logic       m,
    input  logic [3:0] xt,
    input  logic       ordy,
    output logic       acc,
    output logic       got,
    output logic       stall,
    output logic [7:0] od,
    output logic [3:0] ot,
    output logic       have,
    output exp_t       e
  );
    @(negedge clk);
    in_valid  = v;
    in_data   = xd;
    in_mode   = m;
    in_tag    = xt;
    out_ready = ordy;
    #1;
    acc   = in_valid && in_ready;
    got   = out_valid && out_ready;
    stall = out_valid && !out_ready;
    od    = out_data;
    ot    = out_tag;
    have  = (sb.size() > 0);
    e     = '{data: 8'h00, tag: 4'h0, cyc: 0};
    if (have) e = sb[0];
    if (got && have) e = sb.pop_front();
    if (acc) sb.push_back('{data: model(xd, m), tag: xt, cyc: cyc});
  endtask

  task automatic run_single(
    input  logic [7:0] x,
    input  logic       m,
    input  logic [3:0] tg,
    output logic       found,
    output logic [7:0] od,
    output logic [3:0] ot,
    output int         lat
  );
    logic acc, got, stall, have;
    logic [7:0] d2;
    logic [3:0] t2;
    exp_t e;
    found = 1'b0;
    lat = -1;
    od = 8'h00;
    ot = 4'h0;
    step(1'b1, x, m, tg, 1'b1, acc, got, stall, d2, t2, have, e);
    for (int k = 0; k < 8 && !found; k++) begin
      step(1'b0, 8'h00, 1'b0, 4'h0, 1'b1, acc, got, stall, d2, t2, have, e);
      if (got) begin
        found = 1'b1;
        od = d2;
        ot = t2;
        lat = cyc - e.cyc;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_out_valid got %b want 0", out_valid);
    end
    n_tests++;
    if (out_data !== 8'h00) begin
      n_fail++;
      $display("FAIL rst_out_data got %h want 00", out_data);
    end
    n_tests++;
    if (out_tag !== 4'h0) begin
      n_fail++;
      $display("FAIL rst_out_tag got %h want 0", out_tag);
    end
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_in_ready got %b want 1", in_ready);
    end
  endtask

  task automatic test_sigmoid();
    logic [7:0] xs[6];
    logic [7:0] ys[6];
    logic found;
    logic [7:0] od;
    logic [3:0] ot;
    int lat;
    xs = '{8'h00, 8'h10, 8'hF0, 8'h30, 8'h50, 8'h80};
    ys = '{8'h08, 8'h0C, 8'h04, 8'h0F, 8'h10, 8'h00};
    for (int i = 0; i < 6; i++) begin
      run_single(xs[i], 1'b0, 4'(i + 1), found, od, ot, lat);
      n_tests++;
      if (!found) begin
        n_fail++;
        $display("FAIL sig_timeout x=%h no output in 8 cycles", xs[i]);
      end else if (od !== ys[i] || ot !== 4'(i + 1)) begin
        n_fail++;
        $display("FAIL sig_value x=%h got %h/%h want %h/%h",
                 xs[i], od, ot, ys[i], 4'(i + 1));
      end
      n_tests++;
      if (lat != 3) begin
        n_fail++;
        $display("FAIL sig_latency x=%h got %0d want 3", xs[i], lat);
      end
    end
  endtask

  task automatic test_tanh();
    logic [7:0] xs[5];
    logic [7:0] y_on[5];
    logic [7:0] y_off[5];
    logic [7:0] want;
    logic found;
    logic [7:0] od;
    logic [3:0] ot;
    int lat;
    xs    = '{8'h10, 8'hF0, 8'h00, 8'h7F, 8'h80};
    y_on  = '{8'h0C, 8'hF4, 8'h00, 8'h10, 8'hF0};
    y_off = '{8'h0C, 8'h04, 8'h08, 8'h10, 8'h00};
    for (int i = 0; i < 5; i++) begin
      want = TANH_ON ? y_on[i] : y_off[i];
      run_single(xs[i], 1'b1, 4'(9 + i), found, od, ot, lat);
      n_tests++;
      if (!found) begin
        n_fail++;
        $display("FAIL tanh_timeout x=%h no output in 8 cycles", xs[i]);
      end else if (od !== want || ot !== 4'(9 + i) || lat != 3) begin
        n_fail++;
        $display("FAIL tanh_value x=%h got %h/%h lat %0d want %h/%h lat 3",
                 xs[i], od, ot, lat, want, 4'(9 + i));
      end
    end
  endtask

  task automatic test_sweep();
    logic acc, got, stall, have;
    logic [7:0] od;
    logic [3:0] ot;
    logic [7:0] x;
    logic m;
    exp_t e;
    int sent, rcvd, steps;
    sent = 0;
    rcvd = 0;
    steps = 0;
    while (rcvd < 512 && steps < 1200) begin
      x = 8'(sent >> 1);
      m = sent[0];
      step(sent < 512, x, m, 4'(sent), 1'b1,
           acc, got, stall, od, ot, have, e);
      steps++;
      if (acc) sent++;
      if (got) begin
        rcvd++;
        n_tests++;
        if (!have || od !== e.data || ot !== e.tag
            || (cyc - e.cyc) != 3) begin
          n_fail++;
          $display("FAIL sweep_out #%0d got %h/%h lat %0d want %h/%h lat 3",
                   rcvd, od, ot, cyc - e.cyc, e.data, e.tag);
        end
      end
    end
    n_tests++;
    if (rcvd != 512 || sb.size() != 0 || steps != 515) begin
      n_fail++;
      $display("FAIL sweep_count got %0d outs in %0d steps want 512 in 515",
               rcvd, steps);
    end
  endtask

  task automatic test_backpressure();
    logic acc, got, stall, have;
    logic [7:0] od;
    logic [3:0] ot;
    logic [7:0] x;
    logic m;
    exp_t e;
    int sent, rcvd, steps;
    sent = 0;
    rcvd = 0;
    steps = 0;
    while (rcvd < 300 && steps < 3000) begin
      x = 8'($urandom);
      m = 1'($urandom);
      step(sent < 300, x, m, 4'($urandom), 1'($urandom),
           acc, got, stall, od, ot, have, e);
      steps++;
      if (acc) sent++;
      if (got) begin
        rcvd++;
        n_tests++;
        if (!have || od !== e.data || ot !== e.tag) begin
          n_fail++;
          $display("FAIL bp_out #%0d got %h/%h want %h/%h",
                   rcvd, od, ot, e.data, e.tag);
        end
      end else if (stall) begin
        n_tests++;
        if (!have || od !== e.data || ot !== e.tag) begin
          n_fail++;
          $display("FAIL bp_stall got %h/%h want held %h/%h",
                   od, ot, e.data, e.tag);
        end
      end
    end
    n_tests++;
    if (rcvd != 300 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL bp_count got %0d outs, %0d left want 300, 0",
               rcvd, sb.size());
    end
  endtask

  task automatic test_reset_midstream();
    logic acc, got, stall, have;
    logic [7:0] od;
    logic [3:0] ot;
    exp_t e;
    logic found;
    int lat;
    int nacc;
    nacc = 0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'(8'h20 + i), 1'b0, 4'(i + 4), 1'b1,
           acc, got, stall, od, ot, have, e);
      if (acc) nacc++;
    end
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    sb.delete();
    n_tests++;
    if (nacc != 3 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_valid accepted %0d out_valid %b want 3, 0",
               nacc, out_valid);
    end
    n_tests++;
    if (out_data !== 8'h00) begin
      n_fail++;
      $display("FAIL midrst_data got %h want 00", out_data);
    end
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_in_ready got %b want 1", in_ready);
    end
    run_single(8'h30, 1'b0, 4'hA, found, od, ot, lat);
    n_tests++;
    if (!found || od !== 8'h0F || ot !== 4'hA || lat != 3) begin
      n_fail++;
      $display("FAIL midrst_next got %h/%h lat %0d want 0f/a lat 3",
               od, ot, lat);
    end
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL midrst_extra %0d unexpected outputs pending want 0",
               sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_sigmoid();
    test_tanh();
    test_sweep();
    test_backpressure();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
